// File: rtl/clk_monitor_pkg.sv
// Shared definitions for the clock monitor: FSM state encoding and parameter defaults.
package clk_monitor_pkg;

    localparam int CNT_W_DEF    = 8;
    localparam int LOCK_CNT_DEF = 4;

    typedef enum logic [1:0] {
        MON_IDLE  = 2'd0,
        MON_ACQ   = 2'd1,
        MON_CHECK = 2'd2
    } mon_state_t;

endpackage

// File: rtl/mon_sync_edge.sv
// Two-flop synchronizer plus history flop; flags every transition of the monitored signal.
module mon_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic edge_det
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level    = s2;
    assign edge_det = s2 ^ s3;

endmodule

// File: rtl/clk_monitor.sv
// Measures each half-period of an asynchronous toggle in clk cycles and flags
// lock, fast, slow and stuck conditions against an expected half-period window.
module clk_monitor
    import clk_monitor_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mon_in,
    input  logic [CNT_W-1:0] exp_half,
    input  logic [CNT_W-1:0] tol,
    input  logic             clr,
    output logic [CNT_W-1:0] meas,
    output logic             meas_valid,
    output logic             locked,
    output logic             err_fast,
    output logic             err_slow,
    output logic             stuck
);

    localparam int             LW        = $clog2(LOCK_CNT + 1);
    localparam logic [LW-1:0]  LOCK_FULL = LW'(LOCK_CNT);
    localparam logic [CNT_W:0] CNT_MAX   = {1'b0, {CNT_W{1'b1}}};

    mon_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [LW-1:0]    lock_cnt, lock_inc;
    logic             mon_edge, level_unused;
    logic [CNT_W:0]   sum, lo, hi, cnt_x;
    logic             in_range, too_fast, slow_hit, cnt_sat;

    mon_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (mon_in),
        .level    (level_unused),
        .edge_det (mon_edge)
    );

    // Window bounds are one bit wider so the clamp/saturate decisions are exact.
    always_comb begin
        sum      = {1'b0, exp_half} + {1'b0, tol};
        hi       = (sum > CNT_MAX) ? CNT_MAX : sum;
        lo       = (exp_half > tol) ? ({1'b0, exp_half} - {1'b0, tol}) : (CNT_W+1)'(1);
        cnt_x    = {1'b0, cnt};
        in_range = (cnt_x >= lo) && (cnt_x <= hi);
        too_fast = cnt_x < lo;
        slow_hit = cnt_x == (hi + (CNT_W+1)'(1));
        cnt_sat  = &cnt;
        lock_inc = (lock_cnt == LOCK_FULL) ? LOCK_FULL : lock_cnt + LW'(1);
    end

    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = MON_IDLE;
        end else begin
            case (state)
                MON_IDLE:  state_next = MON_ACQ;
                MON_ACQ:   if (mon_edge) state_next = MON_CHECK;
                MON_CHECK: state_next = MON_CHECK;
                default:   state_next = MON_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= MON_IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            lock_cnt   <= '0;
            meas       <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            err_fast   <= 1'b0;
            err_slow   <= 1'b0;
            stuck      <= 1'b0;
        end else if (!en || state == MON_IDLE) begin
            cnt        <= '0;
            lock_cnt   <= '0;
            meas       <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            err_fast   <= 1'b0;
            err_slow   <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            // Clear first so a same-cycle error below overrides it.
            if (clr) begin
                err_fast <= 1'b0;
                err_slow <= 1'b0;
                stuck    <= 1'b0;
            end
            if (state == MON_ACQ) begin
                cnt <= mon_edge ? CNT_W'(1) : (cnt_sat ? cnt : cnt + CNT_W'(1));
            end else if (mon_edge) begin
                cnt        <= CNT_W'(1);
                meas       <= cnt;
                meas_valid <= 1'b1;
                if (in_range) begin
                    lock_cnt <= lock_inc;
                    locked   <= (lock_inc == LOCK_FULL);
                end else begin
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                    if (too_fast) err_fast <= 1'b1;
                end
            end else begin
                cnt <= cnt_sat ? cnt : cnt + CNT_W'(1);
                if (slow_hit) begin
                    err_slow <= 1'b1;
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                end
                if (cnt_sat) stuck <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_monitor.sv
// Randomized and directed scoreboard bench for clk_monitor; expected measurements
// come from interval lengths between driven toggles and the window rules.
module tb_clk_monitor;

    localparam int CW = 8;

    logic          clk = 1'b0, rst = 1'b0, en = 1'b0, mon_in = 1'b0, clr = 1'b0;
    logic [CW-1:0] exp_half = '0, tol = '0;
    logic [CW-1:0] meas;
    logic          meas_valid, locked, err_fast, err_slow, stuck;

    typedef struct packed {
        logic [7:0] meas;
        logic       locked;
        logic       fast;
        logic       slow;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_checks = 0, n_fail = 0;
    int   cyc = 0, last_tog = 0, m_lock = 0;
    logic m_fast = 1'b0, m_slow = 1'b0;

    clk_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mon_in     (mon_in),
        .exp_half   (exp_half),
        .tol        (tol),
        .clr        (clr),
        .meas       (meas),
        .meas_valid (meas_valid),
        .locked     (locked),
        .err_fast   (err_fast),
        .err_slow   (err_slow),
        .stuck      (stuck)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_meas"}, 32'(meas), 0);
        chk({tag, "_meas_valid"}, 32'(meas_valid), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_err_fast"}, 32'(err_fast), 0);
        chk({tag, "_err_slow"}, 32'(err_slow), 0);
        chk({tag, "_stuck"}, 32'(stuck), 0);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int lo_of();
        int l;
        l = int'(exp_half) - int'(tol);
        return (l < 1) ? 1 : l;
    endfunction

    function automatic int hi_of();
        int h;
        h = int'(exp_half) + int'(tol);
        return (h > 255) ? 255 : h;
    endfunction

    task automatic model_clear();
        m_lock = 0;
        m_fast = 1'b0;
        m_slow = 1'b0;
    endtask

    // Toggle the source; the interval since the previous toggle is what the DUT must report.
    task automatic tog();
        int   n;
        exp_t e;
        mon_in   = ~mon_in;
        n        = cyc - last_tog;
        last_tog = cyc;
        if (n > hi_of() + 1) m_slow = 1'b1;
        if (n < lo_of()) begin
            m_fast = 1'b1;
            m_lock = 0;
        end else if (n <= hi_of()) begin
            m_lock = (m_lock >= 4) ? 4 : m_lock + 1;
        end else begin
            m_lock = 0;
        end
        e.meas   = 8'(n);
        e.locked = (m_lock == 4);
        e.fast   = m_fast;
        e.slow   = m_slow;
        sbq.push_back(e);
    endtask

    task automatic tog_discard();
        mon_in   = ~mon_in;
        last_tog = cyc;
    endtask

    task automatic start(input int e, input int t);
        en = 1'b0;
        wait_cyc(2);
        exp_half = 8'(e);
        tol      = 8'(t);
        model_clear();
        en = 1'b1;
        wait_cyc(3);
        tog_discard();
    endtask

    task automatic run_n(input int n, input int k);
        repeat (k) begin
            wait_cyc(n);
            tog();
        end
    endtask

    always @(negedge clk) begin
        if (rst && meas_valid) begin
            if (sbq.size() == 0) begin
                chk("meas_valid_unexpected", 32'(meas_valid), 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_meas", 32'(meas), 32'(mon_e.meas));
                chk("sb_locked", 32'(locked), 32'(mon_e.locked));
                chk("sb_err_fast", 32'(err_fast), 32'(mon_e.fast));
                chk("sb_err_slow", 32'(err_slow), 32'(mon_e.slow));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b1;
        wait_cyc(2);

        // Nominal lock
        start(5, 1);
        run_n(5, 6);
        wait_cyc(4);
        chk("nominal_locked", 32'(locked), 1);
        chk("nominal_fast", 32'(err_fast), 0);
        chk("nominal_slow", 32'(err_slow), 0);

        // Asynchronous reset mid-operation, then fresh acquisition
        #2;
        rst    = 1'b0;
        mon_in = 1'b0;
        #1;
        chk_zero("async_rst");
        wait_cyc(2);
        rst = 1'b1;
        model_clear();
        wait_cyc(3);
        tog_discard();
        run_n(5, 4);
        wait_cyc(4);
        chk("relock_after_rst", 32'(locked), 1);

        // One-cycle enable drop
        en = 1'b0;
        wait_cyc(1);
        chk_zero("en_low");
        en = 1'b1;
        model_clear();
        wait_cyc(3);
        tog_discard();
        run_n(5, 4);
        wait_cyc(4);
        chk("relock_after_en", 32'(locked), 1);

        // Fast source, CLR alone and CLR against a new fast error
        start(20, 1);
        wait_cyc(10);
        tog();
        wait_cyc(5);
        clr = 1'b1;
        wait_cyc(1);
        clr    = 1'b0;
        m_fast = 1'b0;
        chk("clr_clears_fast", 32'(err_fast), 0);
        wait_cyc(4);
        tog();
        wait_cyc(2);
        clr = 1'b1;
        wait_cyc(1);
        clr = 1'b0;
        wait_cyc(3);
        chk("clr_vs_fast", 32'(err_fast), 1);
        chk("fast_locked", 32'(locked), 0);

        // Slow source: flag at count hi+1 ahead of the edge
        start(5, 1);
        wait_cyc(8);
        tog();
        wait_cyc(1);
        chk("slow_before_hi1", 32'(err_slow), 0);
        wait_cyc(1);
        chk("slow_at_hi1", 32'(err_slow), 1);
        wait_cyc(4);

        // Edge coinciding with count hi+1 is a measurement, not a slow error
        start(5, 1);
        wait_cyc(7);
        tog();
        wait_cyc(5);
        chk("edge_at_hi1_slow", 32'(err_slow), 0);

        // Stuck after lock
        start(5, 1);
        run_n(5, 5);
        wait_cyc(257);
        chk("stuck_before_sat", 32'(stuck), 0);
        wait_cyc(1);
        chk("stuck_at_sat", 32'(stuck), 1);
        chk("stuck_locked", 32'(locked), 0);
        chk("stuck_slow", 32'(err_slow), 1);

        // Lower bound clamps to 1
        start(2, 5);
        run_n(1, 6);
        wait_cyc(4);
        chk("clamp_fast", 32'(err_fast), 0);
        chk("clamp_locked", 32'(locked), 1);

        // Randomized sessions
        for (int s = 0; s < 6; s++) begin
            int e, t;
            e = int'($urandom_range(10, 2));
            t = int'($urandom_range(3, 0));
            start(e, t);
            for (int i = 0; i < 10; i++) begin
                int n;
                if ($urandom_range(9, 0) < 7) n = int'($urandom_range(hi_of(), lo_of()));
                else                          n = int'($urandom_range(hi_of() + 3, 1));
                wait_cyc(n);
                tog();
            end
            wait_cyc(5);
        end

        wait_cyc(5);
        chk("sb_drained", 32'(sbq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
